// File: rtl/bcd_pkg.sv
// Shared BCD digit type, limits and validity helper for the up/down counter.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_MIN = 4'd0;

    typedef logic [3:0] bcd_digit_t;

    function automatic logic is_bcd(bcd_digit_t d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the up/down counter; steps when step_in is set.
// step_out forwards the carry (up) or borrow (down) to the next digit.
module bcd_digit_counter
    import bcd_pkg::*;
(
    input  logic       Clk,
    input  logic       rst,
    input  logic       UpOrDown,
    input  logic       step_in,
    output bcd_digit_t digit,
    output logic       step_out
);

    bcd_digit_t digit_q, digit_d;

    always_comb begin
        digit_d  = digit_q;
        step_out = 1'b0;
        if (!is_bcd(digit_q)) begin
            // Corrupt code: reload zero and stay silent towards higher digits.
            digit_d = BCD_MIN;
        end else if (step_in) begin
            if (UpOrDown) begin
                step_out = (digit_q == BCD_MAX);
                digit_d  = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
            end else begin
                step_out = (digit_q == BCD_MIN);
                digit_d  = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit = digit_q;

endmodule

// File: rtl/bcd_updown.sv
// Synchronous cascaded BCD up/down counter; all digits update on the same edge.
module bcd_updown
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 1
) (
    input  logic                  Clk,
    input  logic                  rst,
    input  logic                  UpOrDown,
    output logic [4*DIGITS-1:0]   Count
);

    logic [DIGITS:0] step;
    logic            carry_unused;

    assign step[0]      = 1'b1;
    assign carry_unused = step[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : gen_digits
        bcd_digit_counter u_digit (
            .Clk      (Clk),
            .rst      (rst),
            .UpOrDown (UpOrDown),
            .step_in  (step[i]),
            .digit    (Count[4*i +: 4]),
            .step_out (step[i+1])
        );
    end

endmodule

// File: tb/tb_bcd_updown.sv
// Randomised and directed checks of bcd_updown (1 and 2 digits) against an integer model.
module tb_bcd_updown;

    logic       clk = 1'b0;
    logic       rst;
    logic       up_dn;
    logic [3:0] count1;
    logic [7:0] count2;

    int n_tests = 0;
    int n_fail  = 0;
    int v1 = 0;
    int v2 = 0;

    always #5 clk = ~clk;

    bcd_updown u_dut1 (
        .Clk      (clk),
        .rst      (rst),
        .UpOrDown (up_dn),
        .Count    (count1)
    );

    bcd_updown #(.DIGITS(2)) u_dut2 (
        .Clk      (clk),
        .rst      (rst),
        .UpOrDown (up_dn),
        .Count    (count2)
    );

    function automatic logic [7:0] to_bcd(int v);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = 4'(v % 10);
        hi = 4'((v / 10) % 10);
        return {hi, lo};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int next_val(int v, int modulus, logic r, logic d);
        if (r) return 0;
        if (d) return (v + 1) % modulus;
        return (v + modulus - 1) % modulus;
    endfunction

    // Called just after a negedge: drive, clock, then sample on the next negedge.
    task automatic tick(input string tag, input logic r, input logic d);
        rst   = r;
        up_dn = d;
        @(posedge clk);
        v1 = next_val(v1, 10, r, d);
        v2 = next_val(v2, 100, r, d);
        @(negedge clk);
        check({tag, "_d1"}, {4'h0, count1}, to_bcd(v1));
        check({tag, "_d2"}, count2, to_bcd(v2));
    endtask

    task automatic inject_illegal(input logic d);
        force u_dut1.gen_digits[0].u_digit.digit_q = 4'hC;
        #4;
        release u_dut1.gen_digits[0].u_digit.digit_q;
        rst   = 1'b0;
        up_dn = d;
        @(posedge clk);
        v1 = 0;
        v2 = next_val(v2, 100, 1'b0, d);
        @(negedge clk);
        check("illegal_recover", {4'h0, count1}, 8'h00);
        check("illegal_other", count2, to_bcd(v2));
        tick("illegal_next", 1'b0, d);
        check("illegal_next_val", {4'h0, count1}, d ? 8'h01 : 8'h09);
    endtask

    initial begin
        rst   = 1'b1;
        up_dn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1 = 0;
        v2 = 0;
        check("reset_d1", {4'h0, count1}, 8'h00);
        check("reset_d2", count2, 8'h00);

        // Up through 9 -> 0 wrap, then down through 0 -> 9 wrap.
        for (int i = 0; i < 12; i++) tick("up", 1'b0, 1'b1);
        check("up_wrap_d1", {4'h0, count1}, 8'h02);
        check("up_carry_d2", count2, 8'h12);
        for (int i = 0; i < 4; i++) tick("down", 1'b0, 1'b0);
        check("down_borrow_d1", {4'h0, count1}, 8'h08);
        check("down_borrow_d2", count2, 8'h08);

        // Reset mid-count, then first released edge going down yields all nines.
        tick("rst_mid", 1'b1, 1'b0);
        tick("rst_rel", 1'b0, 1'b0);
        check("rst_rel_nines", count2, 8'h99);
        tick("wrap99", 1'b0, 1'b1);
        check("wrap_99_00", count2, 8'h00);

        // 0x19 / 0x20 boundary with a direction toggle.
        for (int i = 0; i < 19; i++) tick("to19", 1'b0, 1'b1);
        tick("to20", 1'b0, 1'b1);
        check("bound_20", count2, 8'h20);
        tick("back19", 1'b0, 1'b0);
        check("bound_19", count2, 8'h19);

        for (int i = 0; i < 400; i++) begin
            tick("rand", ($urandom_range(0, 19) == 0), 1'($urandom));
        end

        inject_illegal(1'b1);
        inject_illegal(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
